// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a byte on tx_start and shifts it out as
// an 8N1 frame (8E1/8O1 with parity), LSB first, all outputs registered.
module uart_tx_serializer #(
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DIV = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // txd_d is the value the line takes for the state being entered, so txd
  // changes on the same edge as the state register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      txd_d  = 1'b1;
      busy_d = 1'b0;
      if (tx_en && tx_start) begin
        state_d = START;
        shreg_d = tx_data;
        par_d   = (^tx_data) ^ PARITY_ODD;
        cnt_d   = '0;
        bit_d   = '0;
        txd_d   = 1'b0;
        busy_d  = 1'b1;
      end
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      case (state_q)
        START: begin
          state_d = DATA;
          txd_d   = shreg_q[0];
        end
        DATA: begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
            txd_d   = shreg_q[1];
          end
        end
        PARITY: begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
        STOP: begin
          state_d = IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at DIV=16: three instances (8N1, 8E1,
// 8O1) share stimulus; per-cycle outputs are checked against a frame model.
module tb_uart_tx_serializer;

  logic       clk, rst_n, tx_en, tx_start;
  logic [7:0] tx_data;
  logic       txd0, busy0, done0, txde, busye, donee, txdo, busyo, doneo;
  logic [8:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    logic       par_e;
    logic       par_o;
  } vec_t;

  vec_t vecs[6];

  uart_tx_serializer #(.CLOCK_RATE(16), .BAUD_RATE(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_start(tx_start), .tx_data(tx_data),
    .txd(txd0), .busy(busy0), .done(done0));
  uart_tx_serializer #(.CLOCK_RATE(16), .BAUD_RATE(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_start(tx_start), .tx_data(tx_data),
    .txd(txde), .busy(busye), .done(donee));
  uart_tx_serializer #(.CLOCK_RATE(16), .BAUD_RATE(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_o (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .tx_start(tx_start), .tx_data(tx_data),
    .txd(txdo), .busy(busyo), .done(doneo));

  assign outs = {txd0, busy0, done0, txde, busye, donee, txdo, busyo, doneo};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {txd, busy, done} expected i cycles after the accepting edge.
  function automatic logic [2:0] exp_out(input logic [7:0] d, input int i,
                                         input bit pen, input logic p);
    int   n;
    logic t;
    n = pen ? 176 : 160;
    if (i < 16)             t = 1'b0;
    else if (i < 144)       t = d[(i - 16) / 16];
    else if (pen && i < 160) t = p;
    else                    t = 1'b1;
    return {t, (i < n), (i == n)};
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp, input int cyc);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while ((busy0 | busye | busyo) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {8'b0, busy0 | busye | busyo}, 9'b0, k);
  endtask

  task automatic run_frame(input string nm, input vec_t v, input int drop_en_at, input int pulse_at);
    @(posedge clk); #1;
    tx_en = 1'b1; tx_start = 1'b1; tx_data = v.data;
    @(posedge clk); #1;
    tx_start = 1'b0; tx_data = ~v.data;
    for (int i = 0; i <= 180; i++) begin
      @(negedge clk);
      if (i == drop_en_at) tx_en = 1'b0;
      if (i == pulse_at) tx_start = 1'b1;
      if (i == pulse_at + 1) tx_start = 1'b0;
      chk(nm, outs, {exp_out(v.data, i, 1'b0, 1'b0), exp_out(v.data, i, 1'b1, v.par_e),
                     exp_out(v.data, i, 1'b1, v.par_o)}, i);
    end
    tx_en = 1'b1;
  endtask

  initial begin
    int dcnt;
    vecs[0] = '{8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'h07, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b1};

    rst_n = 1'b1; tx_en = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    #2 rst_n = 1'b0;
    #20 chk("reset", outs, 9'b100_100_100, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", outs, 9'b100_100_100, 0);

    // Table: one pulse per vector, all three framings checked per cycle.
    foreach (vecs[k]) begin
      run_frame($sformatf("frame_%02h", vecs[k].data), vecs[k], -1, -1);
      wait_idle("idle_after_frame");
    end

    // Enable gating: start held with tx_en low for 50 cycles is ignored.
    @(posedge clk); #1;
    tx_en = 1'b0; tx_start = 1'b1; tx_data = 8'h5A;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("en_gate_idle", outs, 9'b100_100_100, i);
    end
    run_frame("en_drop_mid", vecs[0], 40, -1);
    wait_idle("idle_after_en_drop");

    // Start pulse while busy is dropped.
    run_frame("busy_reject", vecs[1], -1, 50);
    wait_idle("idle_after_reject");

    // Back-to-back with start held; data changes mid-frame.
    dcnt = 0;
    @(posedge clk); #1;
    tx_en = 1'b1; tx_start = 1'b1; tx_data = 8'h55;
    @(posedge clk); #1;
    for (int i = 0; i <= 330; i++) begin
      logic [2:0] e;
      @(negedge clk);
      if (i == 30) tx_data = 8'hC3;
      if (i == 200) tx_start = 1'b0;
      e = (i <= 160) ? exp_out(8'h55, i, 1'b0, 1'b0) : exp_out(8'hC3, i - 161, 1'b0, 1'b0);
      if (done0) dcnt++;
      chk("b2b", {6'b0, outs[8:6]}, {6'b0, e}, i);
    end
    chk("b2b_done_count", 9'(dcnt), 9'd2, 330);
    wait_idle("idle_after_b2b");

    // Asynchronous reset mid-frame, then a clean frame.
    @(posedge clk); #1;
    tx_en = 1'b1; tx_start = 1'b1; tx_data = 8'hA5;
    @(posedge clk); #1;
    tx_start = 1'b0;
    for (int i = 0; i <= 70; i++) begin
      @(negedge clk);
      chk("pre_reset", outs, {exp_out(8'hA5, i, 1'b0, 1'b0), exp_out(8'hA5, i, 1'b1, 1'b0),
                              exp_out(8'hA5, i, 1'b1, 1'b1)}, i);
    end
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs, 9'b100_100_100, 70);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("after_reset_idle", outs, 9'b100_100_100, i);
    end
    run_frame("clean_after_reset", vecs[0], -1, -1);
    wait_idle("idle_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
